// File: rtl/router_pkg.sv
// Shared constants and types for the router packet datapath register stage.
// Header layout: address in [ADDR_MSB:ADDR_LSB], payload length from LEN_LSB up.
package router_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;

    typedef enum logic [1:0] {
        DOUT_KEEP,
        DOUT_HEADER,
        DOUT_DATA,
        DOUT_HOLD
    } dout_sel_e;

    function automatic logic addr_valid(input logic [1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_pkt_reg_if.sv
// Source-to-FIFO byte bus seen by the router register stage.
// master drives source bytes and the FIFO full flag; slave returns the FIFO write data.
interface router_pkt_reg_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output pkt_valid,
        output data_in,
        output fifo_full,
        input  dout
    );

    modport slave (
        input  pkt_valid,
        input  data_in,
        input  fifo_full,
        output dout
    );
endinterface

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes, compared against the received parity byte.
module router_parity_acc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] pkt_parity,
    output logic                  mismatch
);
    logic [DATA_WIDTH-1:0] int_parity;

    always_ff @(posedge clock) begin
        if (reset) begin
            int_parity <= '0;
        end else if (clear) begin
            int_parity <= '0;
        end else if (enable) begin
            int_parity <= int_parity ^ data;
        end
    end

    assign mismatch = (int_parity != pkt_parity);

endmodule

// File: rtl/router_pkt_reg.sv
// Router datapath register stage: header latch, FIFO byte forwarding, full-stall hold and parity check.
// Define ROUTER_ERR_COUNT_EN to build the saturating parity error counter on err_count.
module router_pkt_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    router_pkt_reg_if.slave       bus,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic [7:0]            err_count
);
    logic [DATA_WIDTH-1:0] header;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] pkt_parity;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  active;
    logic                  hdr_cap;
    logic                  ld_go;
    logic                  ld_stall;
    logic                  parity_byte;
    logic                  acc_en;
    logic                  mismatch;
    dout_sel_e             dout_sel;

    // Everything freezes while the FSM sits in FIFO_FULL_STATE.
    assign active      = !full_state;
    assign hdr_cap     = active && detect_add && bus.pkt_valid
                         && addr_valid(bus.data_in[ADDR_MSB:ADDR_LSB]);
    assign ld_go       = active && ld_state && !bus.fifo_full;
    assign ld_stall    = active && ld_state && bus.fifo_full;
    assign parity_byte = active && ld_state && !bus.pkt_valid;
    assign acc_en      = active && (lfd_state || (ld_state && bus.pkt_valid));
    assign acc_data    = lfd_state ? header : bus.data_in;

    always_comb begin
        dout_sel = DOUT_KEEP;
        if (active) begin
            if (lfd_state)      dout_sel = DOUT_HEADER;
            else if (ld_go)     dout_sel = DOUT_DATA;
            else if (laf_state) dout_sel = DOUT_HOLD;
        end
    end

    router_parity_acc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_acc (
        .clock      (clock),
        .reset      (reset),
        .clear      (hdr_cap),
        .enable     (acc_en),
        .data       (acc_data),
        .pkt_parity (pkt_parity),
        .mismatch   (mismatch)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q        <= '0;
            header        <= '0;
            hold          <= '0;
            pkt_parity    <= '0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
        end else if (active) begin
            if (hdr_cap) begin
                header      <= bus.data_in;
                parity_done <= 1'b0;
                err         <= 1'b0;
            end

            case (dout_sel)
                DOUT_HEADER: dout_q <= header;
                DOUT_DATA:   dout_q <= bus.data_in;
                DOUT_HOLD:   dout_q <= hold;
                default:     dout_q <= dout_q;
            endcase

            if (ld_stall) hold <= bus.data_in;
            if (parity_byte) pkt_parity <= bus.data_in;

            // Parity byte that was stalled behind a full FIFO completes in LOAD_AFTER_FULL.
            if ((parity_byte && !bus.fifo_full)
                || (laf_state && low_pkt_valid && !parity_done))
                parity_done <= 1'b1;

            if (parity_byte)      low_pkt_valid <= 1'b1;
            else if (rst_int_reg) low_pkt_valid <= 1'b0;

            if (rst_int_reg) err <= mismatch;
        end
    end

    assign bus.dout = dout_q;

`ifdef ROUTER_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt_q <= 8'h00;
        end else if (active && rst_int_reg && mismatch && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed self-checking bench for router_pkt_reg; FSM state decodes are driven by hand.
module tb_router_pkt_reg;

    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_DA   = 6'b100000;
    localparam logic [5:0] S_LFD  = 6'b010000;
    localparam logic [5:0] S_LD   = 6'b001000;
    localparam logic [5:0] S_LAF  = 6'b000100;
    localparam logic [5:0] S_FULL = 6'b000010;
    localparam logic [5:0] S_RIR  = 6'b000001;

`ifdef ROUTER_ERR_COUNT_EN
    localparam logic [7:0] CNT_AFTER_BAD = 8'h01;
`else
    localparam logic [7:0] CNT_AFTER_BAD = 8'h00;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       parity_done, low_pkt_valid, err;
    logic [7:0] err_count;

    int n_assert = 0;
    int n_fail   = 0;

    router_pkt_reg_if #(.DATA_WIDTH(8)) bus ();

    router_pkt_reg dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
        .err_count     (err_count)
    );

    always #5 clock = ~clock;

    // Apply inputs, take one rising edge, sample 1ns later.
    task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] din, input logic ff);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
        bus.pkt_valid = pv;
        bus.data_in   = din;
        bus.fifo_full = ff;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_parity_done", {7'd0, parity_done}, 8'h00);
        chk("rst_low_pkt_valid", {7'd0, low_pkt_valid}, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);
        chk("rst_err_count", err_count, 8'h00);
        reset = 1'b0;

        // Good packet to port 1
        cyc(S_DA,  1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h11, 1'b0);  chk("good_hdr", bus.dout, 8'h0D);
        cyc(S_LD,  1'b1, 8'h11, 1'b0);  chk("good_p0", bus.dout, 8'h11);
        cyc(S_LD,  1'b1, 8'h22, 1'b0);  chk("good_p1", bus.dout, 8'h22);
        cyc(S_LD,  1'b1, 8'h33, 1'b0);  chk("good_p2", bus.dout, 8'h33);
        cyc(S_LD,  1'b0, 8'h0D, 1'b0);
        chk("good_par", bus.dout, 8'h0D);
        chk("good_pd", {7'd0, parity_done}, 8'h01);
        chk("good_low", {7'd0, low_pkt_valid}, 8'h01);
        cyc(S_RIR, 1'b0, 8'h00, 1'b0);
        chk("good_err", {7'd0, err}, 8'h00);
        chk("good_low_clr", {7'd0, low_pkt_valid}, 8'h00);

        // Invalid address: header and running parity must be untouched
        cyc(S_DA,  1'b1, 8'h07, 1'b0);
        chk("inv_pd_kept", {7'd0, parity_done}, 8'h01);
        cyc(S_RIR, 1'b0, 8'h00, 1'b0);
        chk("inv_err", {7'd0, err}, 8'h00);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        chk("inv_hdr", bus.dout, 8'h0D);

        // Bad parity
        cyc(S_DA,  1'b1, 8'h0D, 1'b0);
        chk("bad_pd_clr", {7'd0, parity_done}, 8'h00);
        cyc(S_LFD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD,  1'b1, 8'h11, 1'b0);
        cyc(S_LD,  1'b1, 8'h22, 1'b0);
        cyc(S_LD,  1'b1, 8'h33, 1'b0);
        cyc(S_LD,  1'b0, 8'hFF, 1'b0);
        chk("bad_par", bus.dout, 8'hFF);
        chk("bad_err_pre", {7'd0, err}, 8'h00);
        cyc(S_RIR, 1'b0, 8'h00, 1'b0);
        chk("bad_err", {7'd0, err}, 8'h01);
        chk("bad_cnt", err_count, CNT_AFTER_BAD);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        chk("bad_err_hold", {7'd0, err}, 8'h01);

        // FIFO full mid-payload; header capture also clears err
        cyc(S_DA,  1'b1, 8'h0D, 1'b0);
        chk("hdr_clr_err", {7'd0, err}, 8'h00);
        cyc(S_LFD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD,  1'b1, 8'h11, 1'b0);  chk("ff_p0", bus.dout, 8'h11);
        cyc(S_LD,  1'b1, 8'h22, 1'b1);  chk("ff_stall", bus.dout, 8'h11);
        cyc(S_FULL, 1'b1, 8'h55, 1'b1); chk("ff_full_hold", bus.dout, 8'h11);
        cyc(S_LAF, 1'b1, 8'h33, 1'b0);  chk("ff_laf", bus.dout, 8'h22);
        cyc(S_LD,  1'b1, 8'h33, 1'b0);  chk("ff_p2", bus.dout, 8'h33);
        cyc(S_LD,  1'b0, 8'h0D, 1'b0);  chk("ff_par", bus.dout, 8'h0D);
        cyc(S_RIR, 1'b0, 8'h00, 1'b0);
        chk("ff_err", {7'd0, err}, 8'h00);
        chk("ff_cnt", err_count, CNT_AFTER_BAD);

        // FIFO full on the parity byte
        cyc(S_DA,  1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD,  1'b1, 8'h11, 1'b0);
        cyc(S_LD,  1'b1, 8'h22, 1'b0);
        cyc(S_LD,  1'b1, 8'h33, 1'b0);
        cyc(S_LD,  1'b0, 8'h0D, 1'b1);
        chk("fp_low", {7'd0, low_pkt_valid}, 8'h01);
        chk("fp_pd", {7'd0, parity_done}, 8'h00);
        chk("fp_dout", bus.dout, 8'h33);
        cyc(S_FULL, 1'b0, 8'hAA, 1'b1);
        chk("fp_full_pd", {7'd0, parity_done}, 8'h00);
        cyc(S_LAF, 1'b0, 8'h00, 1'b0);
        chk("fp_laf_pd", {7'd0, parity_done}, 8'h01);
        chk("fp_laf_dout", bus.dout, 8'h0D);
        cyc(S_RIR, 1'b0, 8'h00, 1'b0);
        chk("fp_low_clr", {7'd0, low_pkt_valid}, 8'h00);
        chk("fp_err", {7'd0, err}, 8'h00);

        // Set of low_pkt_valid wins over the clear when both are high
        cyc(S_LD | S_RIR, 1'b0, 8'h00, 1'b1);
        chk("low_set_wins", {7'd0, low_pkt_valid}, 8'h01);

        // Reset during payload
        cyc(S_DA,  1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD,  1'b1, 8'h11, 1'b0);  chk("rp_p0", bus.dout, 8'h11);
        reset = 1'b1;
        cyc(S_LD,  1'b1, 8'h22, 1'b0);
        reset = 1'b0;
        chk("rp_dout", bus.dout, 8'h00);
        chk("rp_low", {7'd0, low_pkt_valid}, 8'h00);
        chk("rp_pd", {7'd0, parity_done}, 8'h00);
        chk("rp_cnt", err_count, 8'h00);

        cyc(S_DA,  1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h11, 1'b0);  chk("rp2_hdr", bus.dout, 8'h0D);
        cyc(S_LD,  1'b1, 8'h11, 1'b0);
        cyc(S_LD,  1'b1, 8'h22, 1'b0);
        cyc(S_LD,  1'b1, 8'h33, 1'b0);
        cyc(S_LD,  1'b0, 8'h0D, 1'b0);
        cyc(S_RIR, 1'b0, 8'h00, 1'b0);
        chk("rp2_err", {7'd0, err}, 8'h00);
        chk("rp2_pd", {7'd0, parity_done}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
